st_rmw: RTL and testbench
=========================

Name: st_rmw

Overview:
- Store-side counterpart of the load data converter.
- Takes a store request from the control unit (IR funct3, effective address, rs2 data) and performs the memory write for SB/SH/SW.
- For sub-word stores it runs a read-modify-write over a word-only memory port: read the aligned word, merge the new byte or half into its lane, write the word back.
- Sits between the kappa3-light datapath and the data memory bus, and reports completion, alignment errors and timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for mem_ack in one access before aborting; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle store request, sampled only in IDLE
- ir  in  32  IR value; funct3 = ir[14:12]
- addr  in  32  effective byte address
- wdata  in  32  store data (rs2)
- mem_addr  out  32  word-aligned bus address, {addr[31:2],2'b00}
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_wdata  out  32  bus write data
- mem_be  out  4  byte enables
- mem_rdata  in  32  bus read data, valid while mem_ack=1
- mem_ack  in  1  access complete
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; mem_req, mem_we, done, err, busy = 0; mem_be=4'b1111; mem_addr and mem_wdata = 0; timeout counter = 0.
- Reset mid-operation aborts the transaction immediately. No write is issued after reset deasserts.
- Decode on start (IDLE only; start in any other state is ignored):
  - funct3 000 SB: any offset is legal.
  - funct3 001 SH: requires addr[0]=0.
  - funct3 010 SW: requires addr[1:0]=00.
  - Any other funct3, or a misaligned address, goes to ERR. No bus activity occurs.
- Captured on start: funct3, addr, wdata. Later changes to these inputs are ignored.
- States:
  - IDLE: start with an SW goes to WRITE; start with a legal SB/SH goes to READ; an illegal start goes to ERR.
  - READ: mem_req=1, mem_we=0. On mem_ack, latch mem_rdata into the merge register and go to WRITE.
  - WRITE: mem_req=1, mem_we=1, mem_wdata = merged word (SW: wdata unchanged). On mem_ack go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: done=1 and err=1 for one cycle, then IDLE.
- Merge rules:
  - SB: lane addr[1:0] takes wdata[7:0]; the other lanes keep the read word.
  - SH: lanes {2k+1,2k} with k=addr[1] take wdata[15:0].
  - Upper wdata bits are ignored.
- Latency with ack in the same cycle as the request:
  - SW: start at cycle 0, WRITE at 1, done at 2.
  - SB/SH: READ at 1, WRITE at 2, done at 3.
- mem_req drops in the cycle after mem_ack is seen. mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Timeout: the counter clears on entering READ or WRITE and increments each cycle without mem_ack. On reaching TIMEOUT_CYCLES, mem_req drops and the state goes to ERR.
- An ack arriving in the same cycle the limit is reached wins: the transaction proceeds normally.
- Bus rule: mem_ack outside READ/WRITE is ignored.

Optional Feature:
- Macro: ST_RMW_BYTE_EN_EN.
- Defined: the memory honours mem_be. SB/SH skip READ and go IDLE to WRITE, with data replicated (byte to all 4 lanes, half to both halves). mem_be is one-hot for SB, 0011 or 1100 for SH, 1111 for SW. SB/SH latency equals SW latency.
- Undefined: the RMW path is used and mem_be is constant 4'b1111.

Decomposition:
- Shared package kappa3_pkg holds:
  - funct3 constants F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010.
  - The state enum {IDLE, READ, WRITE, DONE, ERR}.
- One combinational sub-module, st_merge(old_word, data, funct3, offset -> new_word, be), holds the lane merge. It is reused by both the RMW path and the byte-enable path.

Test Plan:
- SB, addr=0x103, wdata=0xAB, memory word 0x11223344, ack with zero wait -> one read, then write 0xAB223344 to 0x100; done at cycle 3, err=0.
- SH, addr=0x202, wdata=0xDEADBEEF, memory word 0x11223344 -> write 0xBEEF3344; with ST_RMW_BYTE_EN_EN: no read, mem_wdata=0xBEEFBEEF, mem_be=1100, done at cycle 2.
- SW, addr=0x300, wdata=0xCAFEBABE -> no read; write 0xCAFEBABE; done at cycle 2.
- SH at addr=0x201, SW at addr=0x302, funct3=011 -> mem_req never asserted; done=err=1 at cycle 1.
- SB with mem_ack withheld and TIMEOUT_CYCLES=4 -> mem_req high for 4 cycles then low; err pulse; busy=0 afterward.
- Assert reset in WRITE before ack -> next cycle mem_req=0 and busy=0; a new start after reset completes normally; start while busy is ignored.

Source files
------------

// File: rtl/kappa3_pkg.sv
// Shared kappa3 definitions: store funct3 codes, store FSM states and the
// small lane helpers used by the store path.
package kappa3_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } st_state_e;

  // A store is legal when its size is known and the offset is naturally aligned.
  function automatic logic st_legal(input logic [2:0] funct3, input logic [1:0] offset);
    logic ok;
    case (funct3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = ~offset[0];
      F3_SW:   ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Copies the store operand into every lane it could land in.
  function automatic logic [31:0] st_replicate(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] word;
    case (funct3)
      F3_SB:   word = {4{data[7:0]}};
      F3_SH:   word = {2{data[15:0]}};
      default: word = data;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/st_merge.sv
// Store lane merge: places a byte/half/word into its lane of a 32-bit word
// and produces the matching byte-enable mask.
module st_merge
  import kappa3_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] new_word,
  output logic [3:0]  be
);

  // Lane placement and byte enables; lanes not written keep old_word.
  always_comb begin
    new_word = old_word;
    be       = 4'b1111;
    case (funct3)
      F3_SB: begin
        new_word[{offset, 3'b000} +: 8] = data[7:0];
        be = 4'b0001 << offset;
      end
      F3_SH: begin
        if (offset[1]) begin
          new_word[31:16] = data[15:0];
          be = 4'b1100;
        end else begin
          new_word[15:0] = data[15:0];
          be = 4'b0011;
        end
      end
      F3_SW: begin
        new_word = data;
        be       = 4'b1111;
      end
      default: begin
        new_word = old_word;
        be       = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/st_rmw.sv
// Store unit for SB/SH/SW over a word-wide bus. Sub-word stores use read-modify-write
// unless ST_RMW_BYTE_EN_EN is defined, in which case they write directly with byte enables.
module st_rmw
  import kappa3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

`ifdef ST_RMW_BYTE_EN_EN
  localparam st_state_e SUB_ENTRY = WRITE;
`else
  localparam st_state_e SUB_ENTRY = READ;
`endif

  st_state_e   state_r;
  st_state_e   state_nx_s;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;
  logic [31:0] cnt_r;

  logic        accept_s;
  logic        legal_s;
  logic        in_access_s;
  logic        timeout_s;
  logic [2:0]  sel_f3_s;
  logic [1:0]  sel_off_s;
  logic [31:0] sel_data_s;
  logic [31:0] old_word_s;
  logic [31:0] merge_word_s;
  logic [3:0]  merge_be_s;

  logic        req_nx_s;
  logic        we_nx_s;
  logic        done_nx_s;
  logic        err_nx_s;
  logic        busy_nx_s;
  logic [31:0] addr_nx_s;
  logic [31:0] wdata_nx_s;
  logic [3:0]  be_nx_s;
  logic        unused_s;

  assign accept_s    = (state_r == IDLE) && start;
  assign legal_s     = st_legal(ir[14:12], addr[1:0]);
  assign in_access_s = (state_r == READ) || (state_r == WRITE);
  assign timeout_s   = (TIMEOUT_CYCLES != 0) && (cnt_r == TO_LAST);

  // In IDLE the merge sees the live request so a direct write can be staged on start.
  assign sel_f3_s   = (state_r == IDLE) ? ir[14:12] : f3_r;
  assign sel_off_s  = (state_r == IDLE) ? addr[1:0] : off_r;
  assign sel_data_s = (state_r == IDLE) ? wdata     : wdata_r;

`ifdef ST_RMW_BYTE_EN_EN
  assign old_word_s = st_replicate(sel_f3_s, sel_data_s);
  assign unused_s   = ^{mem_rdata, ir[31:15], ir[11:0]};
`else
  assign old_word_s = mem_rdata;
  assign unused_s   = ^{merge_be_s, ir[31:15], ir[11:0]};
`endif

  st_merge u_merge (
    .old_word (old_word_s),
    .data     (sel_data_s),
    .funct3   (sel_f3_s),
    .offset   (sel_off_s),
    .new_word (merge_word_s),
    .be       (merge_be_s)
  );

  // State register, captured request and registered bus/status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      f3_r      <= 3'd0;
      off_r     <= 2'd0;
      wdata_r   <= 32'd0;
      cnt_r     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b1111;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      mem_addr  <= addr_nx_s;
      mem_req   <= req_nx_s;
      mem_we    <= we_nx_s;
      mem_wdata <= wdata_nx_s;
      mem_be    <= be_nx_s;
      busy      <= busy_nx_s;
      done      <= done_nx_s;
      err       <= err_nx_s;
      if (accept_s) begin
        f3_r    <= ir[14:12];
        off_r   <= addr[1:0];
        wdata_r <= wdata;
      end
      if (state_nx_s != state_r) begin
        cnt_r <= 32'd0;
      end else if (in_access_s && !mem_ack) begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  // Next-state decode; an ack in the same cycle as the timeout limit still completes.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (!start) begin
          state_nx_s = IDLE;
        end else if (!legal_s) begin
          state_nx_s = ERR;
        end else if (ir[14:12] == F3_SW) begin
          state_nx_s = WRITE;
        end else begin
          state_nx_s = SUB_ENTRY;
        end
      end
      READ: begin
        if (mem_ack) begin
          state_nx_s = WRITE;
        end else if (timeout_s) begin
          state_nx_s = ERR;
        end else begin
          state_nx_s = READ;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_nx_s = DONE;
        end else if (timeout_s) begin
          state_nx_s = ERR;
        end else begin
          state_nx_s = WRITE;
        end
      end
      DONE:    state_nx_s = IDLE;
      ERR:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output values for the coming state; bus fields only change when an access begins.
  always_comb begin
    req_nx_s  = (state_nx_s == READ) || (state_nx_s == WRITE);
    we_nx_s   = (state_nx_s == WRITE);
    done_nx_s = (state_nx_s == DONE) || (state_nx_s == ERR);
    err_nx_s  = (state_nx_s == ERR);
    busy_nx_s = (state_nx_s != IDLE);

    if (accept_s && req_nx_s) begin
      addr_nx_s = {addr[31:2], 2'b00};
    end else begin
      addr_nx_s = mem_addr;
    end

    if ((state_nx_s == WRITE) && (state_r != WRITE)) begin
      wdata_nx_s = merge_word_s;
`ifdef ST_RMW_BYTE_EN_EN
      be_nx_s    = merge_be_s;
`else
      be_nx_s    = 4'b1111;
`endif
    end else begin
      wdata_nx_s = mem_wdata;
`ifdef ST_RMW_BYTE_EN_EN
      be_nx_s    = mem_be;
`else
      be_nx_s    = 4'b1111;
`endif
    end
  end

endmodule

// File: tb/tb_st_rmw.sv
// Self-checking bench for st_rmw: directed plan items plus randomized stores
// against a behavioural memory/store model.
module tb_st_rmw;
  import kappa3_pkg::*;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int fails  = 0;

  // Bus responder state (written only by the responder process)
  logic [31:0] bus_mem [0:255];
  int          wait_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [31:0] last_raddr = 32'd0;
  logic [3:0]  last_be = 4'd0;
  logic        stab_bad = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_wd = 32'd0;

  // Controls from the stimulus process
  int          wait_cycles = 0;
  logic        ack_en = 1'b1;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_val = 32'd0;

  logic [31:0] ref_mem [0:255];

  st_rmw #(.TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ir        (ir),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  assign mem_ack   = mem_req && ack_en && (wait_cnt >= wait_cycles);
  assign mem_rdata = bus_mem[mem_addr[9:2]];

  // Word memory honouring byte enables, with transfer logging and stability tracking.
  always @(posedge clock) begin
    if (pre_en) bus_mem[pre_idx] <= pre_val;
    if (mem_ack && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) bus_mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
      last_be    <= mem_be;
    end
    if (mem_ack && !mem_we) begin
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= mem_addr;
    end
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mem_req && prev_req && !prev_ack &&
        (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wd))
      stab_bad <= 1'b1;
    prev_req  <= mem_req;
    prev_ack  <= mem_ack;
    prev_we   <= mem_we;
    prev_addr <= mem_addr;
    prev_wd   <= mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    ref_mem[idx] = v;
    pre_idx = 8'(idx);
    pre_val = v;
    pre_en  = 1'b1;
    tick();
    pre_en  = 1'b0;
  endtask

  // Word after the store lands, from the lane rules with plain masks and shifts.
  function automatic logic [31:0] stored_word(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
    logic [31:0] mask;
    int sh;
    if (f3 == F3_SB) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((d & 32'hFF) << sh);
    end else if (f3 == F3_SH) begin
      sh = 16 * int'(a[1]);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((d & 32'hFFFF) << sh);
    end else begin
      return d;
    end
  endfunction

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input int w, input bit inject, input string tag);
    bit legal, rmw;
    int lat, k, rd0, wr0, idx;
    logic [31:0] nw, bus_wd;
    logic [3:0] bus_be;
    legal = (f3 == F3_SB) || (f3 == F3_SH && a[0] == 1'b0) || (f3 == F3_SW && a[1:0] == 2'b00);
    idx = int'(a[9:2]);
    nw = stored_word(f3, a, d, ref_mem[idx]);
`ifdef ST_RMW_BYTE_EN_EN
    rmw = 1'b0;
    if (f3 == F3_SB) begin
      bus_wd = (d & 32'hFF) * 32'h01010101;
      bus_be = 4'b0001 << a[1:0];
    end else if (f3 == F3_SH) begin
      bus_wd = (d & 32'hFFFF) * 32'h00010001;
      bus_be = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      bus_wd = d;
      bus_be = 4'b1111;
    end
`else
    rmw = (f3 != F3_SW);
    bus_wd = nw;
    bus_be = 4'b1111;
`endif
    lat = !legal ? 1 : (2 + w + (rmw ? 1 + w : 0));
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    wait_cycles = w;
    ack_en = 1'b1;
    ir = {17'($urandom), f3, 12'($urandom)};
    addr = a;
    wdata = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    ir = $urandom;
    addr = $urandom;
    wdata = $urandom;
    k = 1;
    while (done !== 1'b1 && k < 60) begin
      if (inject && k == 1) begin
        start = 1'b1;
        ir = {17'($urandom), F3_SB, 12'($urandom)};
        addr = 32'h101;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    check({tag, ":latency"}, k, lat);
    check({tag, ":err"}, err, !legal);
    tick();
    check({tag, ":done_pulse"}, done, 1'b0);
    check({tag, ":busy_after"}, busy, 1'b0);
    check({tag, ":reads"}, rd_cnt - rd0, (legal && rmw) ? 1 : 0);
    check({tag, ":writes"}, wr_cnt - wr0, legal ? 1 : 0);
    if (legal) begin
      check({tag, ":waddr"}, last_waddr, {a[31:2], 2'b00});
      check({tag, ":wdata"}, last_wdata, bus_wd);
      check({tag, ":be"}, last_be, bus_be);
      ref_mem[idx] = nw;
    end
    if (legal && rmw) check({tag, ":raddr"}, last_raddr, {a[31:2], 2'b00});
  endtask

  initial begin
    int wr0, rd0, bad;
    logic [2:0] f3;

    reset = 1'b0;
    start = 1'b0;
    ir = 32'd0;
    addr = 32'd0;
    wdata = 32'd0;
    tick();
    tick();
    check("rst:busy", busy, 1'b0);
    check("rst:mem_req", mem_req, 1'b0);
    check("rst:mem_we", mem_we, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:err", err, 1'b0);
    check("rst:mem_be", mem_be, 4'b1111);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 256; i++) preload(i, $urandom);
    preload(64, 32'h11223344);
    preload(128, 32'h11223344);

    run(F3_SB, 32'h103, 32'h000000AB, 0, 1'b0, "sb_103");
`ifdef ST_RMW_BYTE_EN_EN
    check("sb_103:word", last_wdata, 32'hABABABAB);
`else
    check("sb_103:word", last_wdata, 32'hAB223344);
`endif
    run(F3_SH, 32'h202, 32'hDEADBEEF, 0, 1'b0, "sh_202");
`ifdef ST_RMW_BYTE_EN_EN
    check("sh_202:word", last_wdata, 32'hBEEFBEEF);
`else
    check("sh_202:word", last_wdata, 32'hBEEF3344);
`endif
    run(F3_SW, 32'h300, 32'hCAFEBABE, 0, 1'b0, "sw_300");
    run(F3_SH, 32'h201, 32'h12345678, 0, 1'b0, "sh_misalign");
    run(F3_SW, 32'h302, 32'h12345678, 0, 1'b0, "sw_misalign");
    run(3'b011, 32'h100, 32'h12345678, 0, 1'b0, "f3_011");

    // Withheld ack: four request cycles, then the error pulse
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    ack_en = 1'b0;
    ir = {17'd0, F3_SB, 12'h023};
    addr = 32'h105;
    wdata = 32'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("timeout:req_held", mem_req, 1'b1);
      tick();
    end
    check("timeout:req_drop", mem_req, 1'b0);
    check("timeout:done", done, 1'b1);
    check("timeout:err", err, 1'b1);
    tick();
    check("timeout:busy_after", busy, 1'b0);
    check("timeout:no_transfer", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

    // Reset while a write is pending
    wr0 = wr_cnt;
    ir = {17'd0, F3_SW, 12'h023};
    addr = 32'h300;
    wdata = 32'h12345678;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_mid:req_before", mem_req, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_mid:req", mem_req, 1'b0);
    check("rst_mid:busy", busy, 1'b0);
    ack_en = 1'b1;
    tick();
    tick();
    tick();
    check("rst_mid:no_write", wr_cnt - wr0, 0);
    check("rst_mid:idle", busy, 1'b0);
    run(F3_SW, 32'h300, $urandom, 2, 1'b1, "start_while_busy");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(3, 7));
      run(f3, 32'($urandom_range(0, 1023)), $urandom, int'($urandom_range(0, 3)), 1'b0, "rnd");
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (bus_mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);
    check("bus_stable", stab_bad, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
